// File: rtl/store_rmw.sv
// Store path for a word-only data memory: word stores go straight out, byte/half
// stores read the old word, merge the new lane(s), and write the whole word back.
module store_rmw #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] address,
  input  logic [31:0] wdata,
  input  logic [1:0]  storesel,
  output logic [31:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [31:0] mem_rdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_wdata,
  output logic [3:0]  byte_en,
  output logic        done,
  output logic        err
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, ERR} state_t;

  state_t      state, state_nxt;
  logic [31:0] addr_q, data_q, merge_q, merged;
  logic [1:0]  sel_q;
  logic [2:0]  cnt_q;
  logic        bad_req;

  always_comb begin
    bad_req = (storesel == 2'b11) ||
              (storesel == 2'b01 && address[0]) ||
              (storesel == 2'b00 && address[1:0] != 2'b00);
  end

  // Lanes not covered by the store keep the word just read from memory.
  always_comb begin
    merged = mem_rdata;
    if (sel_q == 2'b10)
      merged[{addr_q[1:0], 3'b000} +: 8] = data_q[7:0];
    else if (addr_q[1])
      merged[31:16] = data_q[15:0];
    else
      merged[15:0] = data_q[15:0];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (bad_req)                 state_nxt = ERR;
          else if (storesel == 2'b00)  state_nxt = WRITE;
          else                         state_nxt = READ;
        end
      end
      READ:        state_nxt = WAIT;
      WAIT:        if (cnt_q == 3'd1) state_nxt = WRITE;
      WRITE, ERR:  state_nxt = IDLE;
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      sel_q   <= '0;
      merge_q <= '0;
      cnt_q   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && req_valid) begin
        addr_q <= address;
        data_q <= wdata;
        sel_q  <= storesel;
      end
      if (state == READ) begin
        cnt_q <= 3'(RD_LAT);
      end else if (state == WAIT) begin
        cnt_q <= cnt_q - 3'd1;
        if (cnt_q == 3'd1) merge_q <= merged;
      end
    end
  end

  // All strobes are pure state decodes, so an async reset kills a pending write at once.
  always_comb begin
    req_ready = (state == IDLE);
    mem_rd_en = (state == READ);
    mem_wr_en = (state == WRITE);
    done      = (state == WRITE);
    err       = (state == ERR);
    mem_wdata = '0;
    byte_en   = '0;
    if (state == WRITE) begin
      case (sel_q)
        2'b00: begin
          mem_wdata = data_q;
          byte_en   = 4'b1111;
        end
        2'b01: begin
          mem_wdata = merge_q;
          byte_en   = addr_q[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          mem_wdata = merge_q;
          byte_en   = 4'b0001 << addr_q[1:0];
        end
      endcase
    end
  end

  assign mem_addr = {addr_q[31:2], 2'b00};

endmodule

// File: tb/tb_store_rmw.sv
// Bench for store_rmw: an RD_LAT=1 and an RD_LAT=3 instance share a latency-accurate
// memory model; expected writes are queued at issue and popped when a write appears.
module tb_store_rmw;
  logic clk = 1'b0;
  logic reset;
  logic [31:0] address, wdata;
  logic [1:0]  storesel;
  logic        req_valid1, req_valid3;
  logic        ready1, rd_en1, wr_en1, done1, err1;
  logic        ready3, rd_en3, wr_en3, done3, err3;
  logic [31:0] maddr1, mwdata1, rdata1, maddr3, mwdata3, rdata3;
  logic [3:0]  be1, be3;
  logic [31:0] mem_word;
  logic [31:0] pipe1;
  logic [31:0] pipe3 [3];
  localparam logic [31:0] POISON = 32'hBAD0_BAD0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          lat;
  } exp_t;
  exp_t exp_q[$];
  int n_run = 0, n_fail = 0;

  always #5 clk = ~clk;

  store_rmw #(.RD_LAT(1)) u_dut1 (
    .clk(clk), .reset(reset), .req_valid(req_valid1), .req_ready(ready1),
    .address(address), .wdata(wdata), .storesel(storesel),
    .mem_addr(maddr1), .mem_rd_en(rd_en1), .mem_rdata(rdata1),
    .mem_wr_en(wr_en1), .mem_wdata(mwdata1), .byte_en(be1), .done(done1), .err(err1));

  store_rmw #(.RD_LAT(3)) u_dut3 (
    .clk(clk), .reset(reset), .req_valid(req_valid3), .req_ready(ready3),
    .address(address), .wdata(wdata), .storesel(storesel),
    .mem_addr(maddr3), .mem_rd_en(rd_en3), .mem_rdata(rdata3),
    .mem_wr_en(wr_en3), .mem_wdata(mwdata3), .byte_en(be3), .done(done3), .err(err3));

  // Read data is valid only RD_LAT cycles after the strobe; otherwise a poison word.
  always @(posedge clk) begin
    pipe1    <= rd_en1 ? mem_word : POISON;
    pipe3[0] <= rd_en3 ? mem_word : POISON;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign rdata1 = pipe1;
  assign rdata3 = pipe3[2];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got no summary, want completion");
    $fatal(1, "timeout");
  end

  task automatic do_store1(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s,
                           output int wc, output int rc, output int rn,
                           output logic [31:0] ra, output logic [31:0] wa,
                           output logic [31:0] wd, output logic [3:0] wb, output logic wdn);
    wc = -1; rc = -1; rn = 0; ra = '0; wa = '0; wd = '0; wb = '0; wdn = 1'b0;
    @(posedge clk); #1;
    address = a; wdata = d; storesel = s; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clk);
      if (rd_en1) begin
        rn++;
        if (rc < 0) begin rc = c; ra = maddr1; end
      end
      if (wr_en1) begin
        wc = c; wa = maddr1; wd = mwdata1; wb = be1; wdn = done1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    n_run++;
    if ({ready1, rd_en1, wr_en1, done1, err1, be1, maddr1, mwdata1} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got ready=%b rd=%b wr=%b done=%b err=%b be=%b addr=%h wdata=%h, want 1 0 0 0 0 0000 0 0",
               ready1, rd_en1, wr_en1, done1, err1, be1, maddr1, mwdata1);
    end
    n_run++;
    if ({ready3, rd_en3, wr_en3, err3} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_state_lat3: got ready/rd/wr/err=%b, want 1000", {ready3, rd_en3, wr_en3, err3});
    end
    @(posedge clk); @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic test_word();
    exp_t e;
    int wc, rc, rn;
    logic [31:0] ra, wa, wd;
    logic [3:0] wb;
    logic wdn;
    exp_q.push_back('{32'h100, 32'hDEADBEEF, 4'b1111, 1});
    do_store1(32'h100, 32'hDEADBEEF, 2'b00, wc, rc, rn, ra, wa, wd, wb, wdn);
    e = exp_q.pop_front();
    n_run++;
    if (wc !== e.lat) begin
      n_fail++; $display("FAIL word_latency: got %0d cycles, want %0d", wc, e.lat);
    end
    n_run++;
    if ({wa, wd, wb, wdn} !== {e.addr, e.data, e.be, 1'b1}) begin
      n_fail++;
      $display("FAIL word_write: got addr=%h data=%h be=%b done=%b, want %h %h %b 1", wa, wd, wb, wdn, e.addr, e.data, e.be);
    end
    n_run++;
    if (rn !== 0) begin
      n_fail++; $display("FAIL word_no_read: got %0d read strobes, want 0", rn);
    end
  endtask

  task automatic test_sub(input string nm, input logic [31:0] a, input logic [31:0] d,
                          input logic [1:0] s, input logic [31:0] mem,
                          input logic [31:0] exp_data, input logic [3:0] exp_be);
    exp_t e;
    int wc, rc, rn;
    logic [31:0] ra, wa, wd;
    logic [3:0] wb;
    logic wdn;
    mem_word = mem;
    exp_q.push_back('{{a[31:2], 2'b00}, exp_data, exp_be, 3});
    do_store1(a, d, s, wc, rc, rn, ra, wa, wd, wb, wdn);
    e = exp_q.pop_front();
    n_run++;
    if (rc !== 1 || rn !== 1 || ra !== e.addr) begin
      n_fail++;
      $display("FAIL %s read: got first=%0d count=%0d addr=%h, want 1 1 %h", nm, rc, rn, ra, e.addr);
    end
    n_run++;
    if (wc !== e.lat) begin
      n_fail++; $display("FAIL %s latency: got %0d cycles, want %0d", nm, wc, e.lat);
    end
    n_run++;
    if ({wa, wd, wb, wdn} !== {e.addr, e.data, e.be, 1'b1}) begin
      n_fail++;
      $display("FAIL %s write: got addr=%h data=%h be=%b done=%b, want %h %h %b 1", nm, wa, wd, wb, wdn, e.addr, e.data, e.be);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] mem, d, a, expd;
    logic [3:0] be;
    mem = 32'hA1B2C3D4;
    for (int lo = 0; lo < 4; lo++) begin
      a    = 32'h400 + 32'(lo);
      d    = 32'hCCCC_CC00 | (32'h5A + 32'(lo));
      expd = (mem & ~(32'hFF << (8 * lo))) | ((d & 32'hFF) << (8 * lo));
      be   = 4'(1 << lo);
      test_sub("byte_lane", a, d, 2'b10, mem, expd, be);
    end
  endtask

  task automatic test_errors();
    logic [31:0] ea [3];
    logic [1:0]  es [3];
    ea[0] = 32'h301; es[0] = 2'b01;
    ea[1] = 32'h102; es[1] = 2'b00;
    ea[2] = 32'h0;   es[2] = 2'b11;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      address = ea[i]; wdata = 32'h12345678; storesel = es[i]; req_valid1 = 1'b1;
      @(posedge clk); #1;
      req_valid1 = 1'b0;
      @(negedge clk);
      n_run++;
      if ({err1, rd_en1, wr_en1, done1} !== 4'b1000) begin
        n_fail++;
        $display("FAIL err_pulse[%0d]: got err/rd/wr/done=%b, want 1000", i, {err1, rd_en1, wr_en1, done1});
      end
      @(negedge clk);
      n_run++;
      if ({err1, ready1, rd_en1, wr_en1} !== 4'b0100) begin
        n_fail++;
        $display("FAIL err_recover[%0d]: got err/ready/rd/wr=%b, want 0100", i, {err1, ready1, rd_en1, wr_en1});
      end
    end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    int lowbad, wrcount, rdcount;
    lowbad = 0; wrcount = 0; rdcount = 0;
    mem_word = 32'h11223344;
    exp_q.push_back('{32'h0, 32'h11225A44, 4'b0010, 5});
    exp_q.push_back('{32'h500, 32'hCAFEF00D, 4'b1111, 7});
    @(posedge clk); #1;
    address = 32'h1; wdata = 32'hFFFF_FF5A; storesel = 2'b10; req_valid3 = 1'b1;
    @(posedge clk); #1;
    address = 32'h500; wdata = 32'hCAFEF00D; storesel = 2'b00;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      if (c <= 5 && ready3) lowbad++;
      if (rd_en3) rdcount++;
      if (c == 6) begin
        n_run++;
        if (ready3 !== 1'b1) begin
          n_fail++; $display("FAIL b2b_ready_c6: got %b, want 1", ready3);
        end
      end
      if (wr_en3) begin
        wrcount++;
        n_run++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL b2b_extra_write: got write in cycle %0d, want none", c);
        end else begin
          e = exp_q.pop_front();
          if ({c, maddr3, mwdata3, be3, done3} !== {e.lat, e.addr, e.data, e.be, 1'b1}) begin
            n_fail++;
            $display("FAIL b2b_write: got cycle=%0d addr=%h data=%h be=%b done=%b, want %0d %h %h %b 1",
                     c, maddr3, mwdata3, be3, done3, e.lat, e.addr, e.data, e.be);
          end
        end
      end
      if (c == 6) begin
        @(posedge clk); #1;
        req_valid3 = 1'b0;
      end
    end
    n_run++;
    if (lowbad !== 0) begin
      n_fail++; $display("FAIL b2b_ready_low: got %0d ready cycles in 1..5, want 0", lowbad);
    end
    n_run++;
    if (wrcount !== 2 || rdcount !== 1) begin
      n_fail++; $display("FAIL b2b_counts: got writes=%0d reads=%0d, want 2 1", wrcount, rdcount);
    end
    exp_q.delete();
  endtask

  task automatic test_reset_mid();
    int wr_seen;
    wr_seen = 0;
    mem_word = 32'h11223344;
    @(posedge clk); #1;
    address = 32'h203; wdata = 32'h77; storesel = 2'b10; req_valid1 = 1'b1;
    @(posedge clk); #1;
    req_valid1 = 1'b0;
    @(negedge clk);
    n_run++;
    if (rd_en1 !== 1'b1) begin
      n_fail++; $display("FAIL rstmid_read: got rd_en=%b in cycle 1, want 1", rd_en1);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    #1;
    n_run++;
    if ({ready1, rd_en1, wr_en1, done1, err1, be1, maddr1, mwdata1} !==
        {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0, 32'h0, 32'h0}) begin
      n_fail++;
      $display("FAIL rstmid_outputs: got ready=%b rd=%b wr=%b done=%b err=%b be=%b addr=%h wdata=%h, want 1 0 0 0 0 0000 0 0",
               ready1, rd_en1, wr_en1, done1, err1, be1, maddr1, mwdata1);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (wr_en1) wr_seen++;
    end
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      if (wr_en1) wr_seen++;
    end
    n_run++;
    if (wr_seen !== 0) begin
      n_fail++; $display("FAIL rstmid_no_write: got %0d write cycles, want 0", wr_seen);
    end
    test_sub("rstmid_after", 32'h203, 32'h77, 2'b10, 32'h11223344, 32'h77223344, 4'b1000);
  endtask

  initial begin
    reset = 1'b1;
    req_valid1 = 1'b0; req_valid3 = 1'b0;
    address = '0; wdata = '0; storesel = '0;
    mem_word = 32'h11223344;
    test_reset();
    test_word();
    test_sub("byte_203", 32'h203, 32'h000000AA, 2'b10, 32'h11223344, 32'hAA223344, 4'b1000);
    test_sub("half_302", 32'h302, 32'hFFFF5566, 2'b01, 32'h11223344, 32'h55663344, 4'b1100);
    test_sub("half_300", 32'h300, 32'hFFFF5566, 2'b01, 32'h11223344, 32'h11225566, 4'b0011);
    test_byte_lanes();
    test_errors();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
